melody_sequencer: RTL and testbench

Plays a stored melody by stepping through a small external song ROM and driving the octave/note/enable inputs of the downstream tone generator. Each ROM word encodes one note or rest and its duration. The block times each note in clock cycles, inserts a short silence between notes, and supports start, pause, stop and loop control from the user-interface logic.

---
 rtl/melody_sequencer.sv | 132 +++++++++++++
 tb/tb_melody_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Song-ROM driven note sequencer: fetches note words, times each note and the
// silent gap after it, and drives the tone generator's shift/note/en inputs.
module melody_sequencer #(
  parameter int TICKS_PER_UNIT = 12_500_000,
  parameter int GAP_TICKS      = 1_000_000,
  parameter int AW             = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  input  logic          stop,
  input  logic          loop,
  input  logic [7:0]    rom_data,
  output logic [AW-1:0] rom_addr,
  output logic [1:0]    shift,
  output logic [2:0]    note,
  output logic          en,
  output logic          playing,
  output logic          done
);

  localparam int TW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    PLAY  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state, next;
  logic [TW-1:0] tick;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    dur_cnt;
  logic          wrap;
  logic          rom_end;
  logic          note_end;
  logic          advance;

  // A wrapped address ends the song just like a terminator word.
  assign rom_end  = wrap || (rom_data[2:0] == 3'd0);
  assign note_end = (tick == TICK_LAST) && (dur_cnt == 3'd1);
  assign advance  = ((state == PLAY) || (state == GAP)) && (next == FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:  if (start) next = FETCH;
      FETCH: next = LOAD;
      LOAD: begin
        if (rom_end) next = loop ? FETCH : DONE;
        else         next = PLAY;
      end
      PLAY:  if (!pause && note_end) next = (GAP_TICKS == 0) ? FETCH : GAP;
      GAP:   if (!pause && gap_cnt == GAP_LAST) next = FETCH;
      DONE:  next = IDLE;
      default: next = IDLE;
    endcase
    if (stop) next = IDLE;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      shift    <= '0;
      note     <= '0;
      en       <= 1'b0;
      playing  <= 1'b0;
      done     <= 1'b0;
      tick     <= '0;
      gap_cnt  <= '0;
      dur_cnt  <= '0;
      wrap     <= 1'b0;
    end else begin
      en      <= 1'b0;
      playing <= (next != IDLE);
      done    <= (next == DONE);
      if (next == IDLE) begin
        rom_addr <= '0;
        wrap     <= 1'b0;
      end else begin
        if (advance) begin
          rom_addr <= rom_addr + 1'b1;
          if (&rom_addr) wrap <= 1'b1;
        end
        case (state)
          LOAD: begin
            if (next == PLAY) begin
              shift   <= rom_data[7:6];
              note    <= rom_data[5:3];
              dur_cnt <= rom_data[2:0];
              tick    <= '0;
              en      <= (rom_data[5:3] != 3'd0);
            end else if (next == FETCH) begin
              rom_addr <= '0;
              wrap     <= 1'b0;
            end
          end
          PLAY: begin
            if (!pause) begin
              if (tick == TICK_LAST) begin
                tick    <= '0;
                dur_cnt <= dur_cnt - 3'd1;
              end else begin
                tick <= tick + 1'b1;
              end
              if (next == PLAY) en <= (note != 3'd0);
              else              gap_cnt <= '0;
            end
          end
          GAP: begin
            if (!pause && next == GAP) gap_cnt <= gap_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboarded bench: a song-level model expands each playback into a
// per-cycle expected trace that a negedge monitor compares against the DUT.
module tb_melody_sequencer;
  localparam int TPU   = 4;
  localparam int GAPT  = 2;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MAXC  = 1024;
  localparam int CAP   = 600;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    sh;
    logic [2:0]    nt;
    logic          en;
    logic          pl;
    logic          dn;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst, start, pause, stop, loop;
  logic [7:0]    rom_data;
  logic [AW-1:0] rom_addr;
  logic [1:0]    shift;
  logic [2:0]    note;
  logic          en, playing, done;

  logic [7:0] rom [DEPTH];
  bit         p   [MAXC];
  bit         lp  [MAXC];
  int         stop_at;
  obs_t       tr[$];
  obs_t       sb[$];
  logic [1:0] msh;
  logic [2:0] mnt;
  int         compared = 0;
  int         mismatched = 0;
  string      tag = "none";

  melody_sequencer #(.TICKS_PER_UNIT(TPU), .GAP_TICKS(GAPT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop), .loop(loop),
    .rom_data(rom_data), .rom_addr(rom_addr), .shift(shift), .note(note),
    .en(en), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic obs_t mk(input int a, input logic e, input logic pl, input logic dn);
    obs_t o;
    o.addr = AW'(a); o.sh = msh; o.nt = mnt; o.en = e; o.pl = pl; o.dn = dn;
    return o;
  endfunction

  task automatic check(input string nm, input obs_t got, input obs_t want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got addr=%0d shift=%0d note=%0d en=%b playing=%b done=%b, want addr=%0d shift=%0d note=%0d en=%b playing=%b done=%b",
               nm, got.addr, got.sh, got.nt, got.en, got.pl, got.dn,
               want.addr, want.sh, want.nt, want.en, want.pl, want.dn);
    end
  endtask

  always @(negedge clk) begin : monitor
    obs_t w;
    if (sb.size() > 0) begin
      w = sb.pop_front();
      check(tag, {rom_addr, shift, note, en, playing, done}, w);
    end
  end

  // Song-level model: entry i of tr is the expected output during cycle i+1
  // after the edge that samples start. p[c]/lp[c] are pause/loop during cycle c.
  task automatic build();
    int a, t, rem, g;
    bit wr;
    logic [7:0] w;
    logic en_n;
    tr.delete();
    a = 0; wr = 0;
    tr.push_back(mk(a, 0, 1, 0));
    while (tr.size() < CAP) begin
      tr.push_back(mk(a, 0, 1, 0));
      t = tr.size();
      w = rom[a];
      if (wr || w[2:0] == 3'd0) begin
        if (lp[t]) begin
          a = 0; wr = 0;
          tr.push_back(mk(a, 0, 1, 0));
          continue;
        end
        tr.push_back(mk(a, 0, 1, 1));
        tr.push_back(mk(0, 0, 0, 0));
        break;
      end
      msh = w[7:6]; mnt = w[5:3];
      rem = int'(w[2:0]) * TPU;
      en_n = (mnt != 3'd0);
      while (rem > 0) begin
        tr.push_back(mk(a, en_n, 1, 0));
        t = tr.size();
        if (p[t]) en_n = 1'b0;
        else begin rem--; en_n = (mnt != 3'd0); end
      end
      g = GAPT;
      while (g > 0) begin
        tr.push_back(mk(a, 0, 1, 0));
        t = tr.size();
        if (!p[t]) g--;
      end
      a = (a + 1) % DEPTH;
      if (a == 0) wr = 1;
      tr.push_back(mk(a, 0, 1, 0));
    end
    if (stop_at >= 1 && stop_at < tr.size()) begin
      while (tr.size() > stop_at) tr.delete(tr.size() - 1);
      msh = tr[tr.size()-1].sh;
      mnt = tr[tr.size()-1].nt;
      tr.push_back(mk(0, 0, 0, 0));
    end
    repeat (3) tr.push_back(mk(0, 0, 0, 0));
  endtask

  task automatic play(input string nm);
    tag = nm;
    build();
    start = 1'b1; pause = p[0]; stop = 1'b0; loop = lp[0];
    for (int i = 1; i <= tr.size(); i++) begin
      @(posedge clk); #1;
      sb.push_back(tr[i-1]);
      start = tr[i-1].pl ? ($urandom_range(0, 7) == 0) : 1'b0;
      pause = p[i]; stop = (i == stop_at); loop = lp[i];
    end
    @(posedge clk); #1;
    start = 1'b0; pause = 1'b0; stop = 1'b0; loop = 1'b0;
  endtask

  task automatic clr();
    for (int i = 0; i < MAXC; i++) begin p[i] = 1'b0; lp[i] = 1'b0; end
    stop_at = MAXC + 1;
  endtask

  task automatic set_rom(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  initial begin
    int mode, drop;
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; loop = 1'b0;
    msh = '0; mnt = '0;
    set_rom(8'h4A, 8'h00, 8'h00, 8'h00);
    clr();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tag = "reset_idle";
    repeat (3) begin @(posedge clk); #1; sb.push_back(mk(0, 0, 0, 0)); end

    // Asynchronous reset in the middle of a note.
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    msh = 2'd1; mnt = 3'd1;
    check("pre_reset_note", {rom_addr, shift, note, en, playing, done}, mk(0, 1, 1, 0));
    rst = 1'b1;
    #1;
    msh = '0; mnt = '0;
    check("reset_async", {rom_addr, shift, note, en, playing, done}, mk(0, 0, 0, 0));
    @(posedge clk); #1 rst = 1'b0;
    tag = "reset_release";
    repeat (4) begin @(posedge clk); #1; sb.push_back(mk(0, 0, 0, 0)); end

    clr(); set_rom(8'h4A, 8'h00, 8'h00, 8'h00); play("single_note");
    clr(); set_rom(8'h43, 8'h00, 8'h00, 8'h00); play("rest");
    clr(); set_rom(8'h4A, 8'h00, 8'h00, 8'h00);
    for (int i = 5; i < 10; i++) p[i] = 1'b1;
    play("pause");
    clr(); set_rom(8'h49, 8'h51, 8'h00, 8'h00);
    for (int i = 0; i < 60; i++) lp[i] = 1'b1;
    play("loop_drop");
    clr(); set_rom(8'h49, 8'h49, 8'h49, 8'h49); play("wrap");
    clr(); set_rom(8'h4A, 8'h00, 8'h00, 8'h00); stop_at = 5; play("stop_mid");

    tag = "start_stop_idle";
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    sb.push_back(mk(0, 0, 0, 0));
    repeat (2) begin @(posedge clk); #1; sb.push_back(mk(0, 0, 0, 0)); end

    for (int r = 0; r < 40; r++) begin
      clr();
      for (int k = 0; k < DEPTH; k++) rom[k] = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 2);
      drop = $urandom_range(5, 150);
      for (int i = 0; i < 800; i++) begin
        p[i]  = ($urandom_range(0, 9) == 0);
        lp[i] = (mode == 1) || (mode == 2 && i < drop);
      end
      if (mode == 1) stop_at = $urandom_range(10, 200);
      else if ($urandom_range(0, 2) == 0) stop_at = $urandom_range(1, 120);
      play($sformatf("random_%0d_mode%0d", r, mode));
    end

    @(posedge clk); #1;
    if (sb.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
